// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, sync, blanking,
// line/frame strobes and a frame counter, all registered together.
module vga_timing_gen #(
  parameter int CNT_W          = 11,
  parameter int HOR_PIXELS     = 1024,
  parameter int HOR_SYNC_START = 1048,
  parameter int HOR_SYNC_END   = 1184,
  parameter int HOR_TOTAL      = 1344,
  parameter int VER_PIXELS     = 768,
  parameter int VER_SYNC_START = 771,
  parameter int VER_SYNC_END   = 777,
  parameter int VER_TOTAL      = 806,
  parameter int HS_POL         = 1,
  parameter int VS_POL         = 1,
  parameter int FRAME_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [CNT_W-1:0]   H_LAST  = CNT_W'(HOR_TOTAL - 1);
  localparam logic [CNT_W-1:0]   V_LAST  = CNT_W'(VER_TOTAL - 1);
  localparam logic [CNT_W-1:0]   H_PIX   = CNT_W'(HOR_PIXELS);
  localparam logic [CNT_W-1:0]   V_PIX   = CNT_W'(VER_PIXELS);
  localparam logic [CNT_W-1:0]   H_SS    = CNT_W'(HOR_SYNC_START);
  localparam logic [CNT_W-1:0]   H_SE    = CNT_W'(HOR_SYNC_END);
  localparam logic [CNT_W-1:0]   V_SS    = CNT_W'(VER_SYNC_START);
  localparam logic [CNT_W-1:0]   V_SE    = CNT_W'(VER_SYNC_END);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [FRAME_W-1:0] FRM_ONE = FRAME_W'(1);
  localparam logic               HS_ACT  = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic               VS_ACT  = (VS_POL != 0) ? 1'b1 : 1'b0;
  // A sync pulse running to the end of the line/frame has an end bound that may not fit CNT_W.
  localparam logic               H_SE_AT_END = (HOR_SYNC_END == HOR_TOTAL) ? 1'b1 : 1'b0;
  localparam logic               V_SE_AT_END = (VER_SYNC_END == VER_TOTAL) ? 1'b1 : 1'b0;

  if (!(HOR_PIXELS < HOR_SYNC_START && HOR_SYNC_START < HOR_SYNC_END &&
        HOR_SYNC_END <= HOR_TOTAL)) begin : g_bad_hor
    $fatal(1, "vga_timing_gen: horizontal timing parameters out of order");
  end
  if (!(VER_PIXELS < VER_SYNC_START && VER_SYNC_START < VER_SYNC_END &&
        VER_SYNC_END <= VER_TOTAL)) begin : g_bad_ver
    $fatal(1, "vga_timing_gen: vertical timing parameters out of order");
  end
  if ((HOR_TOTAL - 1) >= (2 ** CNT_W) || (VER_TOTAL - 1) >= (2 ** CNT_W)) begin : g_bad_w
    $fatal(1, "vga_timing_gen: CNT_W too narrow for HOR_TOTAL/VER_TOTAL");
  end

  logic [CNT_W-1:0]   hcount_q, hcount_d, vcount_q, vcount_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic               line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               h_wrap_s, v_wrap_s;

  // Next-state counters and strobes; flags decode the next counts so they align with them.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_cnt_d   = frame_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    h_wrap_s      = (hcount_q == H_LAST);
    v_wrap_s      = (vcount_q == V_LAST);
    if (en) begin
      if (h_wrap_s) begin
        hcount_d     = '0;
        line_start_d = 1'b1;
        if (v_wrap_s) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + FRM_ONE;
        end else begin
          vcount_d = vcount_q + CNT_ONE;
        end
      end else begin
        hcount_d = hcount_q + CNT_ONE;
      end
    end else begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
    end
    hblnk_d = (hcount_d >= H_PIX);
    vblnk_d = (vcount_d >= V_PIX);
    hsync_d = ((hcount_d >= H_SS) && (H_SE_AT_END || (hcount_d < H_SE))) ? HS_ACT : ~HS_ACT;
    vsync_d = ((vcount_d >= V_SS) && (V_SE_AT_END || (vcount_d < V_SE))) ? VS_ACT : ~VS_ACT;
  end

  // Output registers; reset parks the raster at (0,0) with inactive sync and no strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode (horizontal), inverted-polarity
// small mode (full raster), and a narrow frame counter small mode (wrap + mid-frame reset).
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // default-mode instance
  logic        rst_def, en_def;
  logic [10:0] hc_def, vc_def;
  logic        hs_def, vs_def, hb_def, vb_def, ls_def, fs_def;
  logic [15:0] fc_def;
  vga_timing_gen u_def (
    .clk(clk), .rst_n(rst_def), .en(en_def), .hcount(hc_def), .vcount(vc_def),
    .hsync(hs_def), .vsync(vs_def), .hblnk(hb_def), .vblnk(vb_def),
    .line_start(ls_def), .frame_start(fs_def), .frame_cnt(fc_def));

  // small mode, active-low syncs
  logic        rst_sm, en_sm;
  logic [10:0] hc_sm, vc_sm;
  logic        hs_sm, vs_sm, hb_sm, vb_sm, ls_sm, fs_sm;
  logic [15:0] fc_sm;
  vga_timing_gen #(
    .HOR_PIXELS(12), .HOR_SYNC_START(14), .HOR_SYNC_END(16), .HOR_TOTAL(20),
    .VER_PIXELS(5), .VER_SYNC_START(6), .VER_SYNC_END(7), .VER_TOTAL(8),
    .HS_POL(0), .VS_POL(0)
  ) u_sm (
    .clk(clk), .rst_n(rst_sm), .en(en_sm), .hcount(hc_sm), .vcount(vc_sm),
    .hsync(hs_sm), .vsync(vs_sm), .hblnk(hb_sm), .vblnk(vb_sm),
    .line_start(ls_sm), .frame_start(fs_sm), .frame_cnt(fc_sm));

  // small mode, 2-bit frame counter, active-high syncs
  logic        rst_fw, en_fw;
  logic [10:0] hc_fw, vc_fw;
  logic        hs_fw, vs_fw, hb_fw, vb_fw, ls_fw, fs_fw;
  logic [1:0]  fc_fw;
  vga_timing_gen #(
    .HOR_PIXELS(12), .HOR_SYNC_START(14), .HOR_SYNC_END(16), .HOR_TOTAL(20),
    .VER_PIXELS(5), .VER_SYNC_START(6), .VER_SYNC_END(7), .VER_TOTAL(8),
    .FRAME_W(2)
  ) u_fw (
    .clk(clk), .rst_n(rst_fw), .en(en_fw), .hcount(hc_fw), .vcount(vc_fw),
    .hsync(hs_fw), .vsync(vs_fw), .hblnk(hb_fw), .vblnk(vb_fw),
    .line_start(ls_fw), .frame_start(fs_fw), .frame_cnt(fc_fw));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_def = 1'b0; rst_sm = 1'b0; rst_fw = 1'b0;
    en_def = 1'b0;  en_sm = 1'b0;  en_fw = 1'b0;
    repeat (3) step();
    checks++;
    if ({hc_def, vc_def, hs_def, vs_def, hb_def, vb_def, ls_def, fs_def, fc_def} !== 42'd0) begin
      failures++;
      $display("FAIL reset_def: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, want all 0",
               hc_def, vc_def, hs_def, vs_def, hb_def, vb_def, ls_def, fs_def, fc_def);
    end
    checks++;
    if ({hs_sm, vs_sm, hb_sm, vb_sm, ls_sm, fs_sm} !== 6'b110000 || hc_sm !== 11'd0 || vc_sm !== 11'd0) begin
      failures++;
      $display("FAIL reset_small_pol: hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b h=%0d v=%0d, want hs=1 vs=1 rest 0",
               hs_sm, vs_sm, hb_sm, vb_sm, ls_sm, fs_sm, hc_sm, vc_sm);
    end
    rst_def = 1'b1; rst_sm = 1'b1; rst_fw = 1'b1;
    repeat (2) step();
    checks++;
    if (hc_def !== 11'd0 || ls_def !== 1'b0 || fs_def !== 1'b0) begin
      failures++;
      $display("FAIL release_en0_hold: h=%0d ls=%b fs=%b, want h=0 ls=0 fs=0", hc_def, ls_def, fs_def);
    end
  endtask

  task automatic test_default_line();
    int hs_cnt = 0;
    int ls_cnt = 0;
    en_def = 1'b1;
    for (int cyc = 1; cyc <= 1345; cyc++) begin
      step();
      if (hs_def === 1'b1) hs_cnt++;
      if (ls_def === 1'b1) ls_cnt++;
      case (cyc)
        1023, 1024: begin
          checks++;
          if (hc_def !== 11'(cyc) || hb_def !== (cyc == 1024)) begin
            failures++;
            $display("FAIL hblnk_edge: h=%0d hb=%b, want h=%0d hb=%b", hc_def, hb_def, cyc, cyc == 1024);
          end
        end
        1047, 1048, 1183, 1184: begin
          checks++;
          if (hs_def !== (cyc == 1048 || cyc == 1183)) begin
            failures++;
            $display("FAIL hsync_edge: h=%0d hs=%b, want %b", hc_def, hs_def, cyc == 1048 || cyc == 1183);
          end
        end
        1344: begin
          checks++;
          if (hc_def !== 11'd0 || vc_def !== 11'd1 || ls_def !== 1'b1 || fs_def !== 1'b0 ||
              vs_def !== 1'b0 || vb_def !== 1'b0) begin
            failures++;
            $display("FAIL first_line_wrap: h=%0d v=%0d ls=%b fs=%b vs=%b vb=%b, want 0 1 1 0 0 0",
                     hc_def, vc_def, ls_def, fs_def, vs_def, vb_def);
          end
        end
        default: ;
      endcase
    end
    checks++;
    if (hs_cnt != 136 || ls_cnt != 1) begin
      failures++;
      $display("FAIL hsync_width: hsync cycles=%0d line_starts=%0d, want 136 and 1", hs_cnt, ls_cnt);
    end
  endtask

  task automatic test_en_pattern();
    logic [10:0] got [4];
    logic        strobe_seen;
    en_def = 1'b0; step();
    en_def = 1'b1; repeat (4) step();
    checks++;
    if (hc_def !== 11'd5) begin
      failures++;
      $display("FAIL en_setup: h=%0d, want 5", hc_def);
    end
    strobe_seen = 1'b0;
    en_def = 1'b1; step(); got[0] = hc_def;
    en_def = 1'b0; step(); got[1] = hc_def; strobe_seen |= ls_def | fs_def;
    en_def = 1'b0; step(); got[2] = hc_def; strobe_seen |= ls_def | fs_def;
    en_def = 1'b1; step(); got[3] = hc_def;
    checks++;
    if (got[0] !== 11'd6 || got[1] !== 11'd6 || got[2] !== 11'd6 || got[3] !== 11'd7 || strobe_seen !== 1'b0) begin
      failures++;
      $display("FAIL en_pattern: h=%0d,%0d,%0d,%0d strobe=%b, want 6,6,6,7 strobe=0",
               got[0], got[1], got[2], got[3], strobe_seen);
    end
    repeat (1336) step();
    checks++;
    if (hc_def !== 11'd1343) begin
      failures++;
      $display("FAIL en_run_to_end: h=%0d, want 1343", hc_def);
    end
    step();
    checks++;
    if (hc_def !== 11'd0 || vc_def !== 11'd2 || ls_def !== 1'b1) begin
      failures++;
      $display("FAIL second_wrap: h=%0d v=%0d ls=%b, want 0 2 1", hc_def, vc_def, ls_def);
    end
    en_def = 1'b0;
    repeat (2) step();
    checks++;
    if (hc_def !== 11'd0 || vc_def !== 11'd2 || ls_def !== 1'b0 || fs_def !== 1'b0) begin
      failures++;
      $display("FAIL strobe_no_repeat: h=%0d v=%0d ls=%b fs=%b, want 0 2 0 0", hc_def, vc_def, ls_def, fs_def);
    end
  endtask

  task automatic test_small_raster();
    int h, v, bad;
    int first_fs = -1;
    bad = 0;
    en_sm = 1'b1;
    for (int cyc = 1; cyc <= 161; cyc++) begin
      step();
      h = cyc % 20;
      v = (cyc / 20) % 8;
      if (fs_sm === 1'b1 && first_fs < 0) first_fs = cyc;
      if (hc_sm !== 11'(h) || vc_sm !== 11'(v) ||
          hs_sm !== !(h == 14 || h == 15) || vs_sm !== (v != 6) ||
          hb_sm !== (h >= 12) || vb_sm !== (v >= 5) ||
          ls_sm !== (h == 0) || fs_sm !== (cyc == 160)) begin
        bad++;
        if (bad <= 4)
          $display("FAIL small_raster cyc %0d: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b, want h=%0d v=%0d",
                   cyc, hc_sm, vc_sm, hs_sm, vs_sm, hb_sm, vb_sm, ls_sm, fs_sm, h, v);
      end
      if (cyc == 60) begin
        checks++;
        if (hc_sm !== 11'd0 || vc_sm !== 11'd3 || ls_sm !== 1'b1 || fs_sm !== 1'b0) begin
          failures++;
          $display("FAIL line_wrap_mid: h=%0d v=%0d ls=%b fs=%b, want 0 3 1 0", hc_sm, vc_sm, ls_sm, fs_sm);
        end
      end
      if (cyc == 160) begin
        checks++;
        if (hc_sm !== 11'd0 || vc_sm !== 11'd0 || ls_sm !== 1'b1 || fs_sm !== 1'b1 || fc_sm !== 16'd1) begin
          failures++;
          $display("FAIL frame_wrap: h=%0d v=%0d ls=%b fs=%b fc=%0d, want 0 0 1 1 1",
                   hc_sm, vc_sm, ls_sm, fs_sm, fc_sm);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL small_raster_total: bad cycles=%0d, want 0", bad);
    end
    checks++;
    if (first_fs != 160) begin
      failures++;
      $display("FAIL frame_period: first frame_start at cycle %0d, want 160", first_fs);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    logic [1:0] exp_fc [5];
    int idx = 0;
    exp_fc[0] = 2'd1; exp_fc[1] = 2'd2; exp_fc[2] = 2'd3; exp_fc[3] = 2'd0; exp_fc[4] = 2'd1;
    en_fw = 1'b1;
    for (int cyc = 1; cyc <= 800; cyc++) begin
      step();
      if (fs_fw === 1'b1) begin
        checks++;
        if (idx >= 5 || (cyc % 160) != 0 || fc_fw !== exp_fc[idx]) begin
          failures++;
          $display("FAIL frame_cnt_seq: cyc=%0d idx=%0d fc=%0d, want cyc multiple of 160 fc=%0d",
                   cyc, idx, fc_fw, (idx < 5) ? exp_fc[idx] : 2'd0);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 5) begin
      failures++;
      $display("FAIL frame_cnt_count: frame_starts=%0d, want 5", idx);
    end
  endtask

  task automatic test_mid_reset();
    logic bad_strobe = 1'b0;
    repeat (114) step();
    checks++;
    if (hc_fw !== 11'd14 || vc_fw !== 11'd5 || hs_fw !== 1'b1 || hb_fw !== 1'b1 || vb_fw !== 1'b1 || fc_fw !== 2'd1) begin
      failures++;
      $display("FAIL pre_reset_pos: h=%0d v=%0d hs=%b hb=%b vb=%b fc=%0d, want 14 5 1 1 1 1",
               hc_fw, vc_fw, hs_fw, hb_fw, vb_fw, fc_fw);
    end
    #2 rst_fw = 1'b0;
    #1;
    checks++;
    if (hc_fw !== 11'd0 || vc_fw !== 11'd0 || hs_fw !== 1'b0 || vs_fw !== 1'b0 || hb_fw !== 1'b0 ||
        vb_fw !== 1'b0 || ls_fw !== 1'b0 || fs_fw !== 1'b0 || fc_fw !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, want all 0",
               hc_fw, vc_fw, hs_fw, vs_fw, hb_fw, vb_fw, ls_fw, fs_fw, fc_fw);
    end
    step();
    rst_fw = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c < 20) begin
        if (ls_fw !== 1'b0 || fs_fw !== 1'b0 || hc_fw !== 11'(c)) bad_strobe = 1'b1;
      end
    end
    checks++;
    if (bad_strobe !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_count: early strobe or wrong hcount before first wrap");
    end
    checks++;
    if (hc_fw !== 11'd0 || vc_fw !== 11'd1 || ls_fw !== 1'b1 || fs_fw !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_wrap: h=%0d v=%0d ls=%b fs=%b, want 0 1 1 0", hc_fw, vc_fw, ls_fw, fs_fw);
    end
  endtask

  initial begin
    test_reset();
    test_default_line();
    test_en_pattern();
    test_small_raster();
    test_frame_cnt_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
